wishbone_bus_arbiter: RTL and testbench
=======================================

WISHBONE_BUS_ARBITER -- requirements
Module: wishbone_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max wait for ack/err after slave stb before abort (0 = timeout disabled).
REQ-002 SHALL have parameter ROUND_ROBIN, default 1, meaning alternate priority (1) or fixed priority to m0 (0).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, per master port mN (N=0 instruction, N=1 data), inputs mN_adr 30, mN_dat_w 32, mN_sel 4, mN_cyc 1, mN_stb 1, mN_we 1, mN_cti 3, mN_bte 2.
REQ-006 SHALL have, per master port mN, outputs mN_dat_r 32, mN_ack 1, mN_err 1.
REQ-007 SHALL have slave outputs s_adr 30, s_dat_w 32, s_sel 4, s_cyc 1, s_stb 1, s_we 1, s_cti 3, s_bte 2, and slave inputs s_dat_r 32, s_ack 1, s_err 1.

Function
REQ-008 SHALL implement states IDLE, GRANT0, GRANT1, ABORT in a registered state variable.
REQ-009 IDLE: m0_cyc only -> GRANT0; m1_cyc only -> GRANT1; both -> master selected by priority (REQ-010); neither -> stay.
REQ-010 Priority: ROUND_ROBIN=1 favours master not granted most recently (last_grant register, reset to 1 so m0 wins first); ROUND_ROBIN=0 always favours m0.
REQ-011 Grant latency: s_cyc SHALL assert exactly one cycle after requesting mN_cyc is sampled in IDLE; no combinational path from mN_cyc to grant.
REQ-012 GRANTn: all slave request outputs SHALL equal master n inputs combinationally; mn_ack=s_ack, mn_err=s_err; mN_dat_r=s_dat_r for both masters.
REQ-013 Non-granted master SHALL see ack=0, err=0 at all times.
REQ-014 GRANTn SHALL hold while mn_cyc=1 (bursts, cti/bte and multi-beat cycles never interrupted); mn_cyc=0 -> IDLE, s_cyc low that same cycle.
REQ-015 Outside GRANT0/GRANT1, s_cyc and s_stb SHALL be 0; other slave outputs don't-care but driven from m0.
REQ-016 Timeout counter: width $clog2(TIMEOUT_CYCLES+1); clears on entry to GRANTn and on every s_ack or s_err; increments each GRANTn cycle with s_stb=1 and no ack/err; saturates.
REQ-017 Counter reaching TIMEOUT_CYCLES (non-zero) SHALL: pulse mn_err for one cycle, force s_cyc=s_stb=0 that cycle, -> ABORT.
REQ-018 ABORT: s_cyc=0, both acks/errs 0; stays until aborted master's cyc=0, then IDLE.
REQ-019 s_ack and s_err coincident with timeout expiry: ack/err forwarded, counter clears, no abort.
REQ-020 Slave ack/err while in IDLE or ABORT SHALL be discarded.

Reset
REQ-021 rst=0 SHALL immediately force state=IDLE, last_grant=1, timeout counter=0, hence s_cyc=s_stb=0, m0_ack=m1_ack=m0_err=m1_err=0.
REQ-022 Reset mid-transaction SHALL drop s_cyc asynchronously; no ack forwarded afterwards; first cycle after release is IDLE.

Structure
REQ-023 State enum and Wishbone width constants (address 30, data 32, sel 4) SHALL reside in the shared cva5_types package.
REQ-024 Arbitration, grant mux and timeout SHALL be in one module; no sub-module required.
REQ-025 Combinational output mux SHALL be driven solely from the registered state.

Verification
REQ-026 Single request: m0_cyc=m0_stb=1, adr=30'h100, slave acks 2 cycles later -> s_cyc rises 1 cycle after m0_cyc, s_adr=30'h100, m0_ack=1 one cycle, m1_ack=0.
REQ-027 Simultaneous: m0,m1 cyc rise same cycle, ROUND_ROBIN=1 -> m0 granted first; after m0 drops cyc, m1 granted next cycle after IDLE; repeat -> m1 first on next tie.
REQ-028 Burst hold: m1 4-beat burst (cti=3'b010, last beat 3'b111) while m0 requests throughout -> 4 acks to m1, no switch until m1_cyc=0.
REQ-029 Timeout: TIMEOUT_CYCLES=8, slave never acks -> m0_err pulses exactly 8 cycles after s_stb rose, s_cyc=0 from then, ABORT until m0_cyc drops.
REQ-030 Reset mid-transaction: rst=0 while GRANT1 with s_stb=1 -> s_cyc=0 without clock edge; late s_ack after release -> m1_ack stays 0.
REQ-031 Fixed priority: ROUND_ROBIN=0, both requesting for 3 consecutive transactions -> m0 granted all 3.

Source files
------------

// File: rtl/wishbone_bus_arbiter_pkg.sv
// Shared Wishbone types for the CPU bus fabric: bus widths, the arbiter
// state encoding and the two-master priority pick.
package cva5_types;

  localparam int WB_ADR_W = 30;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } arb_state_t;

  // Returns the master to grant (0 or 1) when at least one cyc is high.
  // On a tie, round-robin picks the master that did not win last time,
  // otherwise m0 always wins.
  function automatic logic pick_winner(input logic cyc0,
                                       input logic cyc1,
                                       input logic last_grant,
                                       input logic round_robin);
    if (cyc0 && cyc1) begin
      return round_robin ? ~last_grant : 1'b0;
    end
    return cyc1;
  endfunction

endpackage

// File: rtl/wishbone_bus_arbiter.sv
// Two-master Wishbone arbiter (m0 = instruction, m1 = data) sharing one
// slave port. The grant is registered, so a new owner only reaches the slave
// one cycle after its cyc is sampled in IDLE. A per-grant watchdog aborts a
// cycle whose slave never answers, reporting err to the owning master.
module wishbone_bus_arbiter
  import cva5_types::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [WB_ADR_W-1:0] m0_adr,
  input  logic [WB_DAT_W-1:0] m0_dat_w,
  input  logic [WB_SEL_W-1:0] m0_sel,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [2:0]          m0_cti,
  input  logic [1:0]          m0_bte,
  output logic [WB_DAT_W-1:0] m0_dat_r,
  output logic                m0_ack,
  output logic                m0_err,

  input  logic [WB_ADR_W-1:0] m1_adr,
  input  logic [WB_DAT_W-1:0] m1_dat_w,
  input  logic [WB_SEL_W-1:0] m1_sel,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [2:0]          m1_cti,
  input  logic [1:0]          m1_bte,
  output logic [WB_DAT_W-1:0] m1_dat_r,
  output logic                m1_ack,
  output logic                m1_err,

  output logic [WB_ADR_W-1:0] s_adr,
  output logic [WB_DAT_W-1:0] s_dat_w,
  output logic [WB_SEL_W-1:0] s_sel,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [2:0]          s_cti,
  output logic [1:0]          s_bte,
  input  logic [WB_DAT_W-1:0] s_dat_r,
  input  logic                s_ack,
  input  logic                s_err
);

  // A zero TIMEOUT_CYCLES disables the watchdog; keep a 1-bit counter then
  // so the declarations stay legal.
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t       state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic             abort_owner_reg, abort_owner_next;
  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  logic granted;
  logic sel_m1;
  logic own_cyc;
  logic own_stb;
  logic abort_cyc;
  logic timeout_hit;

  // Decode the registered state into mux selects and the expiry condition.
  // A slave answer in the expiry cycle wins over the abort.
  always_comb begin
    granted     = (state_reg == GRANT0) || (state_reg == GRANT1);
    sel_m1      = (state_reg == GRANT1);
    own_cyc     = sel_m1 ? m1_cyc : m0_cyc;
    own_stb     = sel_m1 ? m1_stb : m0_stb;
    abort_cyc   = abort_owner_reg ? m1_cyc : m0_cyc;
    timeout_hit = TIMEOUT_EN && granted && own_cyc &&
                  (tmo_cnt_reg == CNT_LIMIT) && !s_ack && !s_err;
  end

  // Grant mux: request lines follow the owner (m0 when nobody owns the bus),
  // responses only reach the owner, read data is broadcast.
  always_comb begin
    s_adr    = sel_m1 ? m1_adr   : m0_adr;
    s_dat_w  = sel_m1 ? m1_dat_w : m0_dat_w;
    s_sel    = sel_m1 ? m1_sel   : m0_sel;
    s_we     = sel_m1 ? m1_we    : m0_we;
    s_cti    = sel_m1 ? m1_cti   : m0_cti;
    s_bte    = sel_m1 ? m1_bte   : m0_bte;
    s_cyc    = granted && own_cyc && !timeout_hit;
    s_stb    = granted && own_stb && !timeout_hit;
    m0_dat_r = s_dat_r;
    m1_dat_r = s_dat_r;
    m0_ack   = (state_reg == GRANT0) && s_ack;
    m1_ack   = (state_reg == GRANT1) && s_ack;
    m0_err   = (state_reg == GRANT0) && (s_err || timeout_hit);
    m1_err   = (state_reg == GRANT1) && (s_err || timeout_hit);
  end

  // Next-state logic: arbitration in IDLE, hold for the whole cycle while
  // granted, watchdog counting, and parking in ABORT until the owner lets go.
  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    abort_owner_next = abort_owner_reg;
    tmo_cnt_next     = tmo_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        tmo_cnt_next = '0;
        if (m0_cyc || m1_cyc) begin
          last_grant_next = pick_winner(m0_cyc, m1_cyc, last_grant_reg,
                                        ROUND_ROBIN != 0);
          state_next      = last_grant_next ? GRANT1 : GRANT0;
        end
      end

      GRANT0, GRANT1: begin
        if (!own_cyc) begin
          state_next   = IDLE;
          tmo_cnt_next = '0;
        end else if (timeout_hit) begin
          state_next       = ABORT;
          abort_owner_next = sel_m1;
          tmo_cnt_next     = '0;
        end else if (s_ack || s_err) begin
          tmo_cnt_next = '0;
        end else if (own_stb && (tmo_cnt_reg != CNT_LIMIT)) begin
          tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
        end
      end

      ABORT: begin
        tmo_cnt_next = '0;
        if (!abort_cyc) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next   = IDLE;
        tmo_cnt_next = '0;
      end
    endcase
  end

  // State register; reset lands in IDLE with m0 favoured on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      abort_owner_reg <= 1'b0;
      tmo_cnt_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      last_grant_reg  <= last_grant_next;
      abort_owner_reg <= abort_owner_next;
      tmo_cnt_reg     <= tmo_cnt_next;
    end
  end

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Bench for wishbone_bus_arbiter: a round-robin and a fixed-priority instance
// share one stimulus; directed scenarios first, then random masters and a
// random slave. A cycle-level reference model tracks who owns the bus.
module tb_wishbone_bus_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [29:0] m_adr   [2];
  logic [31:0] m_dat_w [2];
  logic [3:0]  m_sel   [2];
  logic        m_cyc   [2];
  logic        m_stb   [2];
  logic        m_we    [2];
  logic [2:0]  m_cti   [2];
  logic [1:0]  m_bte   [2];
  logic [31:0] s_dat_r;
  logic        s_ack;
  logic        s_err;

  logic [29:0] o_s_adr   [2];
  logic [31:0] o_s_dat_w [2];
  logic [3:0]  o_s_sel   [2];
  logic        o_s_cyc   [2];
  logic        o_s_stb   [2];
  logic        o_s_we    [2];
  logic [2:0]  o_s_cti   [2];
  logic [1:0]  o_s_bte   [2];
  logic [31:0] o_dat_r   [2][2];
  logic        o_ack     [2][2];
  logic        o_err     [2][2];

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    wishbone_bus_arbiter #(
      .TIMEOUT_CYCLES(TMO),
      .ROUND_ROBIN   ((gi == 0) ? 1 : 0)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .m0_adr  (m_adr[0]),   .m0_dat_w(m_dat_w[0]), .m0_sel(m_sel[0]),
      .m0_cyc  (m_cyc[0]),   .m0_stb  (m_stb[0]),   .m0_we (m_we[0]),
      .m0_cti  (m_cti[0]),   .m0_bte  (m_bte[0]),
      .m0_dat_r(o_dat_r[gi][0]), .m0_ack(o_ack[gi][0]), .m0_err(o_err[gi][0]),
      .m1_adr  (m_adr[1]),   .m1_dat_w(m_dat_w[1]), .m1_sel(m_sel[1]),
      .m1_cyc  (m_cyc[1]),   .m1_stb  (m_stb[1]),   .m1_we (m_we[1]),
      .m1_cti  (m_cti[1]),   .m1_bte  (m_bte[1]),
      .m1_dat_r(o_dat_r[gi][1]), .m1_ack(o_ack[gi][1]), .m1_err(o_err[gi][1]),
      .s_adr   (o_s_adr[gi]),   .s_dat_w(o_s_dat_w[gi]), .s_sel(o_s_sel[gi]),
      .s_cyc   (o_s_cyc[gi]),   .s_stb  (o_s_stb[gi]),   .s_we (o_s_we[gi]),
      .s_cti   (o_s_cti[gi]),   .s_bte  (o_s_bte[gi]),
      .s_dat_r (s_dat_r), .s_ack(s_ack), .s_err(s_err)
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model, one copy per instance: owner is -1 when the bus is
  // free; an owner whose cycle timed out is parked until it drops cyc.
  int owner     [2];
  bit parked    [2];
  int prev_win  [2];
  int waited    [2];

  bit          seen_scyc [2];
  bit          seen_ack  [2][2];
  bit          seen_err  [2][2];
  logic [29:0] seen_adr  [2];
  bit          exp_ack0  [2];
  bit          exp_err0  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d]    = -1;
      parked[d]   = 1'b0;
      prev_win[d] = 1;
      waited[d]   = 0;
    end
  endtask

  function automatic bit expired(input int d);
    if (owner[d] < 0 || parked[d]) return 1'b0;
    return m_cyc[owner[d]] && (waited[d] == TMO) && !s_ack && !s_err;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model says for this cycle.
  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      bit g  = (owner[d] >= 0) && !parked[d];
      int n  = g ? owner[d] : 0;
      bit ex = expired(d);
      chk($sformatf("d%0d_s_cyc", d),   32'(o_s_cyc[d]),   32'(g && m_cyc[n] && !ex));
      chk($sformatf("d%0d_s_stb", d),   32'(o_s_stb[d]),   32'(g && m_stb[n] && !ex));
      chk($sformatf("d%0d_s_adr", d),   32'(o_s_adr[d]),   32'(m_adr[n]));
      chk($sformatf("d%0d_s_dat_w", d), o_s_dat_w[d],      m_dat_w[n]);
      chk($sformatf("d%0d_s_sel", d),   32'(o_s_sel[d]),   32'(m_sel[n]));
      chk($sformatf("d%0d_s_we", d),    32'(o_s_we[d]),    32'(m_we[n]));
      chk($sformatf("d%0d_s_cti", d),   32'(o_s_cti[d]),   32'(m_cti[n]));
      chk($sformatf("d%0d_s_bte", d),   32'(o_s_bte[d]),   32'(m_bte[n]));
      for (int k = 0; k < 2; k++) begin
        bit e_ack = g && (k == n) && s_ack;
        bit e_err = g && (k == n) && (s_err || ex);
        chk($sformatf("d%0d_m%0d_dat_r", d, k), o_dat_r[d][k], s_dat_r);
        chk($sformatf("d%0d_m%0d_ack", d, k), 32'(o_ack[d][k]), 32'(e_ack));
        chk($sformatf("d%0d_m%0d_err", d, k), 32'(o_err[d][k]), 32'(e_err));
        seen_ack[d][k] = (o_ack[d][k] === 1'b1);
        seen_err[d][k] = (o_err[d][k] === 1'b1);
        if (d == 0) begin
          exp_ack0[k] = e_ack;
          exp_err0[k] = e_err;
        end
      end
      seen_scyc[d] = (o_s_cyc[d] === 1'b1);
      seen_adr[d]  = o_s_adr[d];
    end
  endtask

  // Advance the model on a rising edge using the inputs the DUT sampled.
  task automatic model_step();
    if (!rst) return;
    for (int d = 0; d < 2; d++) begin
      if (parked[d]) begin
        if (!m_cyc[owner[d]]) begin
          parked[d] = 1'b0;
          owner[d]  = -1;
        end
      end else if (owner[d] >= 0) begin
        if (!m_cyc[owner[d]]) owner[d] = -1;
        else if (expired(d)) parked[d] = 1'b1;
        else if (s_ack || s_err) waited[d] = 0;
        else if (m_stb[owner[d]] && waited[d] < TMO) waited[d]++;
      end else if (m_cyc[0] || m_cyc[1]) begin
        int w;
        if (m_cyc[0] && m_cyc[1]) w = (d == 0) ? 1 - prev_win[d] : 0;
        else w = m_cyc[1] ? 1 : 0;
        owner[d]    = w;
        prev_win[d] = w;
        waited[d]   = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drop(input int k);
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      drop(k);
      m_adr[k] = '0; m_dat_w[k] = '0; m_sel[k] = '0;
      m_we[k] = 1'b0; m_cti[k] = '0; m_bte[k] = '0;
      exp_ack0[k] = 1'b0; exp_err0[k] = 1'b0;
    end
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
  endtask

  task automatic set_req(input int k, input logic [29:0] adr, input logic [2:0] cti);
    m_cyc[k]   = 1'b1;
    m_stb[k]   = 1'b1;
    m_adr[k]   = adr;
    m_dat_w[k] = $urandom;
    m_sel[k]   = 4'($urandom);
    m_we[k]    = 1'($urandom);
    m_cti[k]   = cti;
    m_bte[k]   = 2'($urandom);
  endtask

  // Asynchronous reset pulse taken between clock edges.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
  endtask

  // Both masters raise cyc together, the winner gets one ack, then both
  // withdraw so the next round is again a clean tie.
  task automatic tie_round(input int round);
    set_req(0, 30'h200, 3'b000);
    set_req(1, 30'h300, 3'b000);
    cycle();
    cycle();
    chk($sformatf("tie%0d_rr_winner", round), 32'(seen_adr[0]),
        (round % 2 == 0) ? 32'h200 : 32'h300);
    chk($sformatf("tie%0d_fixed_winner", round), 32'(seen_adr[1]), 32'h200);
    s_ack = 1'b1;
    cycle();
    s_ack = 1'b0;
    drop(0);
    drop(1);
    cycle();
    cycle();
    $display("tie round %0d done", round);
  endtask

  initial begin
    int rise, err_at, acks_m0, acks_m1, stall;

    // Reset held: requests and a stray slave ack must not get through.
    rst = 1'b0;
    idle_inputs();
    model_reset();
    set_req(0, 30'h11, 3'b000);
    s_ack = 1'b1;
    repeat (3) cycle();
    chk("reset_s_cyc", 32'(seen_scyc[0]), 32'd0);
    chk("reset_m0_ack", 32'(seen_ack[0][0]), 32'd0);
    idle_inputs();
    rst = 1'b1;
    cycle();
    $display("reset checked");

    // Ties: round-robin alternates m0/m1, fixed priority stays on m0.
    for (int r = 0; r < 3; r++) tie_round(r);

    // Single request with a slave answering two cycles after the grant.
    do_reset();
    set_req(0, 30'h100, 3'b000);
    cycle();
    chk("single_s_cyc_not_yet", 32'(seen_scyc[0]), 32'd0);
    cycle();
    chk("single_s_cyc_granted", 32'(seen_scyc[0]), 32'd1);
    chk("single_s_adr", 32'(seen_adr[0]), 32'h100);
    cycle();
    s_ack = 1'b1;
    cycle();
    chk("single_m0_ack", 32'(seen_ack[0][0]), 32'd1);
    chk("single_m1_ack", 32'(seen_ack[0][1]), 32'd0);
    s_ack = 1'b0;
    drop(0);
    cycle();
    cycle();
    $display("single request done");

    // m1 four-beat burst while m0 waits; m0 must not cut in.
    set_req(1, 30'h40, 3'b010);
    cycle();
    set_req(0, 30'h80, 3'b000);
    acks_m0 = 0;
    acks_m1 = 0;
    for (int b = 0; b < 4; b++) begin
      s_ack    = 1'b1;
      m_adr[1] = 30'h40 + 30'(b);
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      cycle();
      acks_m1 += int'(seen_ack[0][1]);
      acks_m0 += int'(seen_ack[0][0]);
    end
    chk("burst_m1_acks", acks_m1, 4);
    chk("burst_m0_acks", acks_m0, 0);
    s_ack = 1'b0;
    drop(1);
    cycle();
    cycle();
    cycle();
    chk("burst_then_m0_adr", 32'(seen_adr[0]), 32'h80);
    s_ack = 1'b1;
    cycle();
    s_ack = 1'b0;
    drop(0);
    cycle();
    cycle();
    $display("burst hold done");

    // Silent slave: err must arrive TMO cycles after s_stb rose.
    set_req(0, 30'h55, 3'b000);
    rise   = -1;
    err_at = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (seen_scyc[0] && rise < 0) rise = i;
      if (seen_err[0][0] && err_at < 0) err_at = i;
    end
    chk("timeout_latency", err_at - rise, TMO);
    chk("abort_s_cyc_low", 32'(seen_scyc[0]), 32'd0);
    drop(0);
    cycle();
    cycle();
    $display("timeout done");

    // Ack landing exactly on the expiry cycle is forwarded, no abort.
    set_req(0, 30'h66, 3'b000);
    repeat (TMO + 1) cycle();
    s_ack = 1'b1;
    cycle();
    chk("tie_expiry_ack", 32'(seen_ack[0][0]), 32'd1);
    chk("tie_expiry_err", 32'(seen_err[0][0]), 32'd0);
    s_ack = 1'b0;
    cycle();
    chk("tie_expiry_still_cyc", 32'(seen_scyc[0]), 32'd1);
    drop(0);
    cycle();
    cycle();
    $display("ack at expiry done");

    // Reset in the middle of an m1 grant: s_cyc falls with no clock edge.
    set_req(1, 30'h77, 3'b000);
    cycle();
    cycle();
    #2;
    rst   = 1'b0;
    s_ack = 1'b1;
    model_reset();
    #1;
    chk("midreset_s_cyc_rr", 32'(o_s_cyc[0]), 32'd0);
    chk("midreset_s_cyc_fixed", 32'(o_s_cyc[1]), 32'd0);
    chk("midreset_m1_ack", 32'(o_ack[0][1]), 32'd0);
    @(posedge clk);
    #1;
    drop(1);
    rst = 1'b1;
    cycle();
    chk("late_ack_m1", 32'(seen_ack[0][1]), 32'd0);
    s_ack = 1'b0;
    cycle();
    $display("mid-transaction reset done");

    // Random masters and slave, including stalls long enough to time out.
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_cyc[k]) begin
          if ($urandom_range(0, 2) == 0) set_req(k, 30'($urandom), 3'($urandom));
        end else if (exp_err0[k]) begin
          drop(k);
        end else if (exp_ack0[k]) begin
          if ($urandom_range(0, 1) == 0) drop(k);
          else set_req(k, m_adr[k] + 30'd1, 3'($urandom));
        end else if ($urandom_range(0, 29) == 0) begin
          drop(k);
        end
      end
      s_ack   = 1'b0;
      s_err   = 1'b0;
      s_dat_r = $urandom;
      if (stall > 0) begin
        stall--;
      end else begin
        int r = $urandom_range(0, 15);
        if (r < 5) s_ack = 1'b1;
        else if (r == 5) s_err = 1'b1;
        else if (r == 6) stall = $urandom_range(5, 14);
      end
      cycle();
    end
    $display("random phase done");

    idle_inputs();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
